// File: rtl/serial_rx_pkg.sv
// Shared constants and state encoding for the serial frame receiver.
package serial_rx_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_DATA   = 2'd1;
    localparam logic [STATE_W-1:0] ST_PARITY = 2'd2;
    localparam logic [STATE_W-1:0] ST_STOP   = 2'd3;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } state_t;

endpackage

// File: rtl/serial_bit_counter.sv
// Data-bit position counter: modulus-WIDTH up-counter with clear, enable and terminal flag.
module serial_bit_counter #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last_c
);

    assign last_c = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last_c ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start '1', WIDTH data bits LSB-first, [even parity], stop '0'.
// Optional parity checking is enabled by defining PARITY_CHECK_EN.
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Din,
    output logic [WIDTH-1:0] Dout,
    output logic             Valid,
    output logic             FrameErr,
`ifdef PARITY_CHECK_EN
    output logic             ParErr,
`endif
    output logic             Busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             cnt_last_c;
`ifdef PARITY_CHECK_EN
    logic             par_bit;
`endif

    // Counter only runs while shifting data; held at zero otherwise so each frame starts at bit 0
    serial_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (state != S_DATA),
        .en     (state == S_DATA),
        .cnt    (cnt),
        .last_c (cnt_last_c)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            shreg    <= '0;
            Dout     <= '0;
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            Busy     <= 1'b0;
`ifdef PARITY_CHECK_EN
            ParErr   <= 1'b0;
            par_bit  <= 1'b0;
`endif
        end else begin
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
`ifdef PARITY_CHECK_EN
            ParErr   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (Din == START_BIT) begin
                        state <= S_DATA;
                        Busy  <= 1'b1;
                    end
                end
                S_DATA: begin
                    shreg[cnt] <= Din;
                    if (cnt_last_c) begin
`ifdef PARITY_CHECK_EN
                        state <= S_PARITY;
`else
                        state <= S_STOP;
`endif
                    end
                end
`ifdef PARITY_CHECK_EN
                S_PARITY: begin
                    par_bit <= Din;
                    state   <= S_STOP;
                end
`endif
                S_STOP: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                    // Payload is delivered even on parity error; only a bad stop bit discards it
                    if (Din == STOP_BIT) begin
                        Dout  <= shreg;
                        Valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                        ParErr <= (^shreg) ^ par_bit;
`endif
                    end else begin
                        FrameErr <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: frame-level reference model builds a per-cycle expectation stream.
module tb_serial_frame_rx;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Din;
    logic [W-1:0] Dout;
    logic         Valid;
    logic         FrameErr;
    logic         Busy;
`ifdef PARITY_CHECK_EN
    logic         ParErr;
`endif

    always #5 CLK = ~CLK;

    serial_frame_rx #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Din      (Din),
        .Dout     (Dout),
        .Valid    (Valid),
        .FrameErr (FrameErr),
`ifdef PARITY_CHECK_EN
        .ParErr   (ParErr),
`endif
        .Busy     (Busy)
    );

    typedef struct {
        logic         din;
        logic         busy;
        logic         valid;
        logic         ferr;
        logic         perr;
        logic [W-1:0] dout;
    } step_t;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [W-1:0] model_dout;
    step_t        steps[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One serial bit plus the outputs expected after the edge that samples it
    task automatic push(input logic d, input logic busy, input logic valid,
                        input logic ferr, input logic perr);
        step_t s;
        s.din   = d;
        s.busy  = busy;
        s.valid = valid;
        s.ferr  = ferr;
        s.perr  = perr;
        s.dout  = model_dout;
        steps.push_back(s);
    endtask

    task automatic add_frame(input logic [W-1:0] data, input logic par,
                             input logic stop, input int gap);
        logic perr;
        perr = 1'b0;
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < int'(W); i++) push(data[i], 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef PARITY_CHECK_EN
        push(par, 1'b1, 1'b0, 1'b0, 1'b0);
        perr = (^data) ^ par;
`else
        perr = par & 1'b0;
`endif
        if (stop == 1'b0) model_dout = data;
        push(stop, 1'b0, ~stop, stop, ~stop & perr);
        for (int g = 0; g < gap; g++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run();
        step_t s;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            @(negedge CLK);
            Din = s.din;
            @(posedge CLK);
            #1;
            check("valid", 32'(Valid), 32'(s.valid));
            check("frame_err", 32'(FrameErr), 32'(s.ferr));
            check("busy", 32'(Busy), 32'(s.busy));
            check("dout", 32'(Dout), 32'(s.dout));
`ifdef PARITY_CHECK_EN
            check("par_err", 32'(ParErr), 32'(s.perr));
`endif
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_dout"}, 32'(Dout), 32'h0);
        check({tag, "_valid"}, 32'(Valid), 32'h0);
        check({tag, "_frame_err"}, 32'(FrameErr), 32'h0);
        check({tag, "_busy"}, 32'(Busy), 32'h0);
`ifdef PARITY_CHECK_EN
        check({tag, "_par_err"}, 32'(ParErr), 32'h0);
`endif
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RST = 1'b1;
        Din = 1'b1;
        #1;
        check({tag, "_async_busy"}, 32'(Busy), 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check_idle_zero(tag);
        @(negedge CLK);
        Din = 1'b0;
        RST = 1'b0;
        model_dout = '0;
    endtask

    initial begin
        RST = 1'b1;
        Din = 1'b0;
        model_dout = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_idle_zero("por");
        @(negedge CLK);
        RST = 1'b0;

        // Good frame, then same frame with a bad stop bit
        add_frame(8'hA5, 1'b0, 1'b0, 2);
        add_frame(8'hA5, 1'b0, 1'b1, 1);
        run();

        // Back-to-back frames with no idle gap
        add_frame(8'h3C, 1'b0, 1'b0, 0);
        add_frame(8'hFF, 1'b0, 1'b0, 3);
        run();

        // Line stuck high: repeated frame errors, never stuck busy
        add_frame(8'hFF, 1'b1, 1'b1, 0);
        add_frame(8'hFF, 1'b1, 1'b1, 0);
        add_frame(8'hFF, 1'b1, 1'b1, 2);
        run();

        // Reset after four data bits discards the partial frame
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run();
        do_reset("mid");
        add_frame(8'h01, 1'b1, 1'b0, 2);
        run();

`ifdef PARITY_CHECK_EN
        add_frame(8'hA5, 1'b0, 1'b0, 1);
        add_frame(8'hA5, 1'b1, 1'b0, 1);
        run();
`endif

        // Random frames, parity, stop errors and gaps
        for (int n = 0; n < 60; n++) begin
            add_frame(W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        end
        run();

        do_reset("end");
        add_frame(W'($urandom), 1'($urandom), 1'b0, 1);
        run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
